// File: rtl/tblink_rpc_cmd_engine.sv
// tblink RPC command engine.
// Accepts byte commands on a ready/valid target port and answers on a ready/valid
// initiator port. It can drive a gated core clock and a core reset pulse. It can
// snapshot the design outputs (dat_i) and load the design inputs (dat_o).
module tblink_rpc_cmd_engine #(
    parameter int N_IN_BYTES  = 1,
    parameter int N_OUT_BYTES = 1,
    parameter int CNT_BYTES   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               t_dat,
    input  logic                     t_valid,
    output logic                     t_ready,
    output logic [7:0]               i_dat,
    output logic                     i_valid,
    input  logic                     i_ready,
    input  logic [8*N_IN_BYTES-1:0]  dat_i,
    output logic [8*N_OUT_BYTES-1:0] dat_o,
    output logic                     cclock,
    output logic                     creset,
    output logic                     busy
);

    localparam int IW = 8 * N_IN_BYTES;
    localparam int OW = 8 * N_OUT_BYTES;
    localparam int CW = 8 * CNT_BYTES;

    // Index of the last response byte of a READ (status byte is index 0).
    localparam logic [4:0] IN_LAST   = 5'(N_IN_BYTES);
    // Index of the last argument byte in each ARGS flavour.
    localparam logic [4:0] OUT_LAST  = 5'(N_OUT_BYTES - 1);
    localparam logic [4:0] CNT_LAST  = 5'(CNT_BYTES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_ADV   = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_CRST  = 2'b11;

    localparam logic [7:0] RSP_READ  = 8'h00;
    localparam logic [7:0] RSP_ADV   = 8'h01;
    localparam logic [7:0] RSP_WRITE = 8'h02;
    localparam logic [7:0] RSP_CRST  = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARGS = 3'd1,
        ST_ADV  = 3'd2,
        ST_CRST = 3'd3,
        ST_RSP  = 3'd4
    } state_t;

    // Registered state and outputs.
    state_t          state_q,    state_d;
    logic            write_q,    write_d;     // ARGS collects WRITE data (1) or a count (0)
    logic [4:0]      arg_idx_q,  arg_idx_d;
    logic [OW-1:0]   stage_q,    stage_d;
    logic [OW-1:0]   dat_o_q,    dat_o_d;
    logic [CW-1:0]   cnt_q,      cnt_d;       // advance count, or remaining creset cycles
    logic            cclock_q,   cclock_d;
    logic            creset_q,   creset_d;
    logic [IW-1:0]   snap_q,     snap_d;
    logic [7:0]      rsp_code_q, rsp_code_d;
    logic [4:0]      rsp_idx_q,  rsp_idx_d;
    logic [4:0]      rsp_last_q, rsp_last_d;
    logic [7:0]      i_dat_q,    i_dat_d;
    logic            i_valid_q,  i_valid_d;
    logic            t_ready_q,  t_ready_d;
    logic            busy_q,     busy_d;

    logic            t_xfer_s;
    logic            rsp_xfer_s;
    logic [1:0]      op_s;
    logic [5:0]      arg_s;

    assign t_xfer_s   = t_valid && t_ready_q;
    assign rsp_xfer_s = i_valid_q && i_ready;
    assign op_s       = t_dat[1:0];
    assign arg_s      = t_dat[7:2];

    // Response byte at a given index: status code first, then snapshot bytes LSB first.
    function automatic logic [7:0] rsp_byte(input logic [7:0]    code,
                                            input logic [IW-1:0] snap,
                                            input logic [4:0]    idx);
        logic [7:0] b;
        b = code;
        for (int j = 0; j < N_IN_BYTES; j++) begin
            if (idx == 5'(j + 1)) begin
                b = snap[8*j +: 8];
            end else begin
                b = b;
            end
        end
        return b;
    endfunction

    // Next-state and next-output computation for the command FSM.
    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        arg_idx_d  = arg_idx_q;
        stage_d    = stage_q;
        dat_o_d    = dat_o_q;
        cnt_d      = cnt_q;
        cclock_d   = cclock_q;
        creset_d   = creset_q;
        snap_d     = snap_q;
        rsp_code_d = rsp_code_q;
        rsp_idx_d  = rsp_idx_q;
        rsp_last_d = rsp_last_q;

        case (state_q)
            ST_IDLE: begin
                cclock_d = 1'b0;
                creset_d = 1'b0;
                if (t_xfer_s) begin
                    case (op_s)
                        OP_READ: begin
                            snap_d     = dat_i;
                            rsp_code_d = RSP_READ;
                            rsp_idx_d  = 5'd0;
                            rsp_last_d = IN_LAST;
                            state_d    = ST_RSP;
                        end
                        OP_ADV: begin
                            if (arg_s != 6'd0) begin
                                cnt_d   = CW'(arg_s);
                                state_d = ST_ADV;
                            end else begin
                                // Extended count follows as CNT_BYTES argument bytes.
                                cnt_d     = '0;
                                arg_idx_d = 5'd0;
                                write_d   = 1'b0;
                                state_d   = ST_ARGS;
                            end
                        end
                        OP_WRITE: begin
                            stage_d   = '0;
                            arg_idx_d = 5'd0;
                            write_d   = 1'b1;
                            state_d   = ST_ARGS;
                        end
                        OP_CRST: begin
                            // cnt holds the remaining high cycles after the first.
                            cnt_d    = CW'(arg_s);
                            creset_d = 1'b1;
                            state_d  = ST_CRST;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ARGS: begin
                cclock_d = 1'b0;
                creset_d = 1'b0;
                if (t_xfer_s) begin
                    if (write_q) begin
                        for (int j = 0; j < N_OUT_BYTES; j++) begin
                            if (arg_idx_q == 5'(j)) begin
                                stage_d[8*j +: 8] = t_dat;
                            end else begin
                                stage_d[8*j +: 8] = stage_d[8*j +: 8];
                            end
                        end
                        if (arg_idx_q == OUT_LAST) begin
                            // All bytes present: update the design inputs in one step.
                            dat_o_d    = stage_d;
                            rsp_code_d = RSP_WRITE;
                            rsp_idx_d  = 5'd0;
                            rsp_last_d = 5'd0;
                            state_d    = ST_RSP;
                        end else begin
                            arg_idx_d = arg_idx_q + 5'd1;
                        end
                    end else begin
                        for (int j = 0; j < CNT_BYTES; j++) begin
                            if (arg_idx_q == 5'(j)) begin
                                cnt_d[8*j +: 8] = t_dat;
                            end else begin
                                cnt_d[8*j +: 8] = cnt_d[8*j +: 8];
                            end
                        end
                        if (arg_idx_q == CNT_LAST) begin
                            if (cnt_d == '0) begin
                                // Zero-length advance: answer at once, no core clock.
                                rsp_code_d = RSP_ADV;
                                rsp_idx_d  = 5'd0;
                                rsp_last_d = 5'd0;
                                state_d    = ST_RSP;
                            end else begin
                                state_d = ST_ADV;
                            end
                        end else begin
                            arg_idx_d = arg_idx_q + 5'd1;
                        end
                    end
                end else begin
                    state_d = ST_ARGS;
                end
            end

            ST_ADV: begin
                creset_d = 1'b0;
                cclock_d = ~cclock_q;
                if (cclock_q) begin
                    // Falling toggle completes one core cycle.
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        rsp_code_d = RSP_ADV;
                        rsp_idx_d  = 5'd0;
                        rsp_last_d = 5'd0;
                        state_d    = ST_RSP;
                    end else begin
                        state_d = ST_ADV;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end

            ST_CRST: begin
                cclock_d = 1'b0;
                if (cnt_q == '0) begin
                    creset_d   = 1'b0;
                    rsp_code_d = RSP_CRST;
                    rsp_idx_d  = 5'd0;
                    rsp_last_d = 5'd0;
                    state_d    = ST_RSP;
                end else begin
                    creset_d = 1'b1;
                    cnt_d    = cnt_q - CNT_ONE;
                end
            end

            ST_RSP: begin
                cclock_d = 1'b0;
                creset_d = 1'b0;
                if (rsp_xfer_s) begin
                    if (rsp_idx_q == rsp_last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        rsp_idx_d = rsp_idx_q + 5'd1;
                    end
                end else begin
                    rsp_idx_d = rsp_idx_q;
                end
            end

            default: begin
                cclock_d = 1'b0;
                creset_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase

        t_ready_d = (state_d == ST_IDLE) || (state_d == ST_ARGS);
        i_valid_d = (state_d == ST_RSP);
        busy_d    = (state_d != ST_IDLE);
        if (state_d == ST_RSP) begin
            i_dat_d = rsp_byte(rsp_code_d, snap_d, rsp_idx_d);
        end else begin
            i_dat_d = 8'h00;
        end
    end

    // State and output registers; reset aborts any operation immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            write_q    <= 1'b0;
            arg_idx_q  <= 5'd0;
            stage_q    <= '0;
            dat_o_q    <= '0;
            cnt_q      <= '0;
            cclock_q   <= 1'b0;
            creset_q   <= 1'b0;
            snap_q     <= '0;
            rsp_code_q <= 8'h00;
            rsp_idx_q  <= 5'd0;
            rsp_last_q <= 5'd0;
            i_dat_q    <= 8'h00;
            i_valid_q  <= 1'b0;
            t_ready_q  <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            arg_idx_q  <= arg_idx_d;
            stage_q    <= stage_d;
            dat_o_q    <= dat_o_d;
            cnt_q      <= cnt_d;
            cclock_q   <= cclock_d;
            creset_q   <= creset_d;
            snap_q     <= snap_d;
            rsp_code_q <= rsp_code_d;
            rsp_idx_q  <= rsp_idx_d;
            rsp_last_q <= rsp_last_d;
            i_dat_q    <= i_dat_d;
            i_valid_q  <= i_valid_d;
            t_ready_q  <= t_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign t_ready = t_ready_q;
    assign i_dat   = i_dat_q;
    assign i_valid = i_valid_q;
    assign dat_o   = dat_o_q;
    assign cclock  = cclock_q;
    assign creset  = creset_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_tblink_rpc_cmd_engine.sv
// Self-checking bench for tblink_rpc_cmd_engine with 2-byte buses and 2-byte counts.
module tb_tblink_rpc_cmd_engine;

    localparam int NI = 2;
    localparam int NO = 2;
    localparam int NC = 2;

    logic            clock = 1'b0;
    logic            reset;
    logic [7:0]      t_dat;
    logic            t_valid;
    logic            t_ready;
    logic [7:0]      i_dat;
    logic            i_valid;
    logic            i_ready;
    logic [8*NI-1:0] dat_i;
    logic [8*NO-1:0] dat_o;
    logic            cclock;
    logic            creset;
    logic            busy;

    int errors = 0;
    int checks = 0;
    int rises = 0;
    int cres_cnt = 0;
    logic cc_prev = 1'b0;

    tblink_rpc_cmd_engine #(
        .N_IN_BYTES (NI),
        .N_OUT_BYTES(NO),
        .CNT_BYTES  (NC)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .t_dat  (t_dat),
        .t_valid(t_valid),
        .t_ready(t_ready),
        .i_dat  (i_dat),
        .i_valid(i_valid),
        .i_ready(i_ready),
        .dat_i  (dat_i),
        .dat_o  (dat_o),
        .cclock (cclock),
        .creset (creset),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    // Count cclock rising edges and creset-high cycles, sampled mid-cycle.
    always @(negedge clock) begin
        cc_prev <= cclock;
        if (cclock && !cc_prev) rises <= rises + 1;
        if (creset) cres_cnt <= cres_cnt + 1;
    end

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  a0;
        logic [7:0]  a1;
        logic [15:0] din;
        logic [7:0]  rsp;
        logic [15:0] data;
        int          lat;
        int          cnt;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(input logic [7:0] cmd, input logic [7:0] a0, input logic [7:0] a1,
                                input logic [15:0] din, input logic [7:0] rsp, input logic [15:0] data,
                                input int lat, input int cnt);
        vec_t v;
        v.cmd = cmd; v.a0 = a0; v.a1 = a1; v.din = din;
        v.rsp = rsp; v.data = data; v.lat = lat; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        t_dat = b;
        t_valid = 1'b1;
        while (!t_ready && n < 2000) begin
            tick();
            n++;
        end
        checks++;
        if (!t_ready) begin
            errors++;
            $display("FAIL send_timeout: t_ready low for %0d cycles", n);
        end
        tick();
        t_valid = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 1;
        while (!i_valid && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (!i_valid) begin
            errors++;
            $display("FAIL valid_timeout: no i_valid after %0d cycles", n);
        end
    endtask

    task automatic recv_byte(output logic [7:0] b);
        int n;
        n = 0;
        i_ready = 1'b1;
        while (!i_valid && n < 2000) begin
            tick();
            n++;
        end
        checks++;
        if (!i_valid) begin
            errors++;
            $display("FAIL recv_timeout: i_valid low for %0d cycles", n);
        end
        b = i_dat;
        tick();
        i_ready = 1'b0;
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int r0, c0, lat;
        logic [1:0] op;
        logic [5:0] arg;
        logic [7:0] b0, b1, b2;
        op  = v.cmd[1:0];
        arg = v.cmd[7:2];
        dat_i = v.din;
        r0 = rises;
        c0 = cres_cnt;
        send_byte(v.cmd);
        if ((op == 2'b01 && arg == 6'd0) || op == 2'b10) begin
            send_byte(v.a0);
            send_byte(v.a1);
        end
        wait_valid(2000, lat);
        check($sformatf("vec%0d_latency", k), lat, v.lat);
        recv_byte(b0);
        check($sformatf("vec%0d_rsp", k), {24'h0, b0}, {24'h0, v.rsp});
        if (op == 2'b00) begin
            recv_byte(b1);
            recv_byte(b2);
            check($sformatf("vec%0d_read_data", k), {16'h0, b2, b1}, {16'h0, v.data});
        end
        if (op == 2'b10) check($sformatf("vec%0d_dat_o", k), {16'h0, dat_o}, {16'h0, v.data});
        check($sformatf("vec%0d_t_ready_after", k), {31'h0, t_ready}, 32'd1);
        check($sformatf("vec%0d_cclock_rises", k), rises - r0, (op == 2'b01) ? v.cnt : 0);
        if (op == 2'b11) check($sformatf("vec%0d_creset_cycles", k), cres_cnt - c0, v.cnt);
    endtask

    // Overall time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b0, b1, b2;
        int lat, r0, c0;

        vecs[0] = mk(8'h00, 8'h00, 8'h00, 16'h1234, 8'h00, 16'h1234, 1, 0);
        vecs[1] = mk(8'h00, 8'h00, 8'h00, 16'h00FF, 8'h00, 16'h00FF, 1, 0);
        vecs[2] = mk(8'h05, 8'h00, 8'h00, 16'h0000, 8'h01, 16'h0000, 3, 1);
        vecs[3] = mk(8'h0D, 8'h00, 8'h00, 16'h0000, 8'h01, 16'h0000, 7, 3);
        vecs[4] = mk(8'hFD, 8'h00, 8'h00, 16'h0000, 8'h01, 16'h0000, 127, 63);
        vecs[5] = mk(8'h02, 8'hCD, 8'hAB, 16'h0000, 8'h02, 16'hABCD, 1, 0);
        vecs[6] = mk(8'h02, 8'hFF, 8'h00, 16'h0000, 8'h02, 16'h00FF, 1, 0);
        vecs[7] = mk(8'h03, 8'h00, 8'h00, 16'h0000, 8'h03, 16'h0000, 2, 1);
        vecs[8] = mk(8'h0B, 8'h00, 8'h00, 16'h0000, 8'h03, 16'h0000, 4, 3);
        vecs[9] = mk(8'h01, 8'h05, 8'h00, 16'h0000, 8'h01, 16'h0000, 11, 5);

        reset = 1'b1; t_dat = 8'h00; t_valid = 1'b0; i_ready = 1'b0; dat_i = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_t_ready", {31'h0, t_ready}, 32'd1);
        check("rst_i_valid", {31'h0, i_valid}, 32'd0);
        check("rst_i_dat",   {24'h0, i_dat}, 32'd0);
        check("rst_cclock",  {31'h0, cclock}, 32'd0);
        check("rst_creset",  {31'h0, creset}, 32'd0);
        check("rst_dat_o",   {16'h0, dat_o}, 32'd0);
        check("rst_busy",    {31'h0, busy}, 32'd0);

        // READ with dat_i changing after the snapshot
        dat_i = 16'hA55A;
        send_byte(8'h00);
        dat_i = 16'hFFFF;
        check("read_busy", {31'h0, busy}, 32'd1);
        check("read_t_ready_low", {31'h0, t_ready}, 32'd0);
        recv_byte(b0);
        recv_byte(b1);
        recv_byte(b2);
        check("read_status", {24'h0, b0}, 32'h00);
        check("read_byte0",  {24'h0, b1}, 32'h5A);
        check("read_byte1",  {24'h0, b2}, 32'hA5);
        check("read_t_ready_back", {31'h0, t_ready}, 32'd1);

        // WRITE with gaps: dat_o untouched until the last byte lands
        send_byte(8'h02);
        repeat (5) tick();
        check("write_gap0_dat_o", {16'h0, dat_o}, 32'd0);
        send_byte(8'h34);
        repeat (5) tick();
        check("write_gap1_dat_o", {16'h0, dat_o}, 32'd0);
        send_byte(8'h12);
        check("write_dat_o", {16'h0, dat_o}, 32'h1234);
        recv_byte(b0);
        check("write_rsp", {24'h0, b0}, 32'h02);

        // Extended ADVANCE of 256
        r0 = rises;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h01);
        wait_valid(2000, lat);
        check("adv256_latency", lat, 513);
        check("adv256_cclock_low", {31'h0, cclock}, 32'd0);
        recv_byte(b0);
        check("adv256_rsp", {24'h0, b0}, 32'h01);
        check("adv256_rises", rises - r0, 256);

        // Extended ADVANCE of 0
        r0 = rises;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_valid(2000, lat);
        check("adv0_latency", lat, 1);
        recv_byte(b0);
        check("adv0_rsp", {24'h0, b0}, 32'h01);
        check("adv0_rises", rises - r0, 0);

        // CRESET arg=2 with response back-pressure
        r0 = rises;
        c0 = cres_cnt;
        send_byte(8'h0B);
        wait_valid(2000, lat);
        check("crst_latency", lat, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("crst_hold%0d_valid", i), {31'h0, i_valid}, 32'd1);
            check($sformatf("crst_hold%0d_dat", i), {24'h0, i_dat}, 32'h03);
            tick();
        end
        recv_byte(b0);
        check("crst_rsp", {24'h0, b0}, 32'h03);
        check("crst_cycles", cres_cnt - c0, 3);
        check("crst_rises", rises - r0, 0);

        // Table-driven vectors
        for (int k = 0; k < 10; k++) begin
            run_vec(k, vecs[k]);
        end

        // Reset in the middle of ADVANCE 10
        send_byte(8'h29);
        tick();
        check("mid_adv_cclock_high", {31'h0, cclock}, 32'd1);
        check("mid_adv_dat_o_set", {16'h0, dat_o}, 32'h00FF);
        reset = 1'b1;
        #1;
        check("rst_adv_cclock",  {31'h0, cclock}, 32'd0);
        check("rst_adv_i_valid", {31'h0, i_valid}, 32'd0);
        check("rst_adv_t_ready", {31'h0, t_ready}, 32'd1);
        check("rst_adv_dat_o",   {16'h0, dat_o}, 32'd0);
        check("rst_adv_busy",    {31'h0, busy}, 32'd0);
        #2;
        reset = 1'b0;
        tick();

        // Reset in the middle of a READ response
        dat_i = 16'hBEEF;
        send_byte(8'h00);
        check("mid_rsp_valid", {31'h0, i_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_rsp_i_valid", {31'h0, i_valid}, 32'd0);
        check("rst_rsp_t_ready", {31'h0, t_ready}, 32'd1);
        check("rst_rsp_busy",    {31'h0, busy}, 32'd0);
        #2;
        reset = 1'b0;
        tick();

        // Normal READ after reset
        dat_i = 16'h0102;
        send_byte(8'h00);
        recv_byte(b0);
        recv_byte(b1);
        recv_byte(b2);
        check("post_rst_status", {24'h0, b0}, 32'h00);
        check("post_rst_data", {16'h0, b2, b1}, 32'h0102);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tblink_rpc_cmd_engine.md
Name: tblink_rpc_cmd_engine

Overview:
- Byte-stream RPC command engine; next generation of the tblink gateway controller.
- Accepts 8-bit commands on a ready/valid target port and returns byte responses on a ready/valid initiator port.
- Drives a gated core clock (cclock) and a core reset (creset) to the design under control.
- Snapshots a parametrised-width input bus (dat_i) and loads a parametrised-width output bus (dat_o).
- Supports extended multi-byte advance counts.

Parameters:
- N_IN_BYTES, 1: byte width of dat_i; legal range 1..16.
- N_OUT_BYTES, 1: byte width of dat_o; legal range 1..16.
- CNT_BYTES, 2: bytes in the extended advance count; legal range 1..4.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- t_dat  in  8  command/payload byte
- t_valid  in  1  command byte valid
- t_ready  out  1  engine accepts byte
- i_dat  out  8  response byte
- i_valid  out  1  response byte valid
- i_ready  in  1  response sink ready
- dat_i  in  8*N_IN_BYTES  sampled design outputs
- dat_o  out  8*N_OUT_BYTES  driven design inputs
- cclock  out  1  gated core clock
- creset  out  1  core reset pulse
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: all state/counters cleared, state=IDLE.
  - t_ready=1, i_valid=0, i_dat=0, cclock=0, creset=0, dat_o=0, busy=0.
- Reset asserted mid-operation aborts everything immediately:
  - pending response dropped; partial dat_o staging discarded; cclock forced low.
- A byte is transferred only on a cycle with valid&&ready high at the posedge.
- t_ready=1 only in IDLE and ARGS. i_valid=1 only in RSP.
- Command byte: opcode=cmd[1:0], arg=cmd[7:2].
- States: IDLE, ARGS, ADV, CRST, RSP.
- IDLE, command accepted, by opcode:
  - 00 READ: snapshot dat_i on the accept edge. Response = 0x00 then N_IN_BYTES data bytes, LSB first. Next state RSP.
  - 01 ADVANCE, arg!=0: count=arg; next state ADV.
  - 01 ADVANCE, arg==0: next state ARGS to collect CNT_BYTES count bytes, LSB first.
  - 10 WRITE: next state ARGS to collect N_OUT_BYTES bytes, LSB first, into a staging register.
  - 11 CRESET: creset=1 from the next cycle for arg+1 cycles; next state CRST.
- ARGS:
  - Accepts one byte per handshake; no timeout.
  - After the last WRITE byte: dat_o updated atomically from staging on that edge. Response 0x02; next state RSP.
  - After the last count byte: count loaded. If count==0, response 0x01 and next state RSP; else next state ADV.
- ADV:
  - cclock toggles every system cycle.
  - count decrements on each cycle where cclock goes 1->0.
  - When a falling toggle makes count 0: cclock ends low, response 0x01, next state RSP.
  - Advance of N is therefore exactly N cclock rising edges over 2N cycles.
  - cclock never toggles outside ADV.
- CRST:
  - creset high for exactly arg+1 cycles; cclock held low.
  - Then creset=0, response 0x03, next state RSP.
- RSP:
  - i_dat presents the current response byte, stable while i_valid&&!i_ready.
  - Each handshake advances the index.
  - Handshake on the last byte: next state IDLE, so t_ready=1 on the following cycle.
  - Response lengths: READ 1+N_IN_BYTES; all others 1 byte.
- Latency from command accept to first i_valid:
  - READ / WRITE-last-byte / zero advance: 1 cycle.
  - ADVANCE N: 2N+1 cycles.
  - CRESET arg: arg+2 cycles.
- dat_i changes after the snapshot do not affect an in-flight READ response.
- t_valid while t_ready=0 is ignored (byte is held by the source).
- Maximum extended count 2^(8*CNT_BYTES)-1; counter must not wrap.

Test Plan:
- Reset, then READ with N_IN_BYTES=2, dat_i=0xA55A. Send 0x00 -> responses 0x00, 0x5A, 0xA5; dat_i changed to 0xFFFF after accept does not alter the response; t_ready high 1 cycle after the last handshake.
- Short ADVANCE: send 0x0D (arg=3) -> exactly 3 cclock rising edges over 6 cycles; cclock low at end; single 0x01 response.
- Extended ADVANCE, CNT_BYTES=2: send 0x01, 0x00, 0x01 -> 256 cclock rising edges, then 0x01. Send 0x01, 0x00, 0x00 -> 0x01 one cycle later with no cclock edge.
- WRITE, N_OUT_BYTES=2: send 0x02, 0x34 then 0x12 with 5-cycle gaps -> dat_o stays 0 until the last accept, then 0x1234 in one step; response 0x02.
- CRESET: send 0x0B (arg=2) -> creset high exactly 3 cycles, cclock static; response 0x03. Hold i_ready=0 for 4 cycles -> i_valid and i_dat stable.
- Assert reset mid-ADVANCE (count 10) and mid-RSP -> cclock=0, i_valid=0, t_ready=1, dat_o=0, busy=0 immediately; next READ behaves normally.
